// File: rtl/cursor_controller.sv
// cursor_controller
//   Moves a BOX x BOX cursor square around an H_RES x V_RES visible area
//   under control of five push buttons and paints it into the pixel stream.
//   Cursor position and colour are updated only once per frame (at the
//   falling edge of vsync), so the square never tears mid-frame.
//   Holding a direction moves once, waits REPEAT_FRAMES frames, then
//   auto-repeats one STEP per frame.
//
// Ports
//   clk        pixel clock, all logic on its rising edge
//   reset      synchronous, active-low
//   video_on   high inside the visible area
//   vsync      vertical sync, active-low pulse
//   pixel_x/y  current scan position
//   B_U/D/L/R/C  debounced buttons, active-high, asynchronous to clk
//   rgb        RGB332 output, one cycle after pixel_x/pixel_y/video_on
//   box_x/y    cursor top-left corner
//   color_idx  current palette index
module cursor_controller #(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int BOX           = 32,
  parameter int STEP          = 8,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_on,
  input  logic       vsync,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       B_U,
  input  logic       B_D,
  input  logic       B_L,
  input  logic       B_R,
  input  logic       B_C,
  output logic [7:0] rgb,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic [2:0] color_idx
);

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT} axis_state_t;

  localparam int CNT_W = $clog2(REPEAT_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REPEAT_FRAMES - 1);

  // Button bit order: 0=U, 1=D, 2=L, 3=R, 4=C
  logic [4:0] btn_raw, btn_meta_reg, btn_sync_reg, btn_prev_reg, btn_rise;
  logic [4:0] pend_reg;
  logic       vs_meta_reg, vs_sync_reg, vs_prev_reg, frame_tick;

  // Axis 0 = horizontal (neg=L, pos=R), axis 1 = vertical (neg=U, pos=D)
  axis_state_t       state_reg  [2];
  axis_state_t       state_next [2];
  logic [CNT_W-1:0]  cnt_reg    [2];
  logic [CNT_W-1:0]  cnt_next   [2];
  logic [9:0]        pos_reg    [2];
  logic [9:0]        pos_next   [2];
  logic signed [10:0] sum_dn    [2];
  logic signed [10:0] sum_up    [2];
  logic signed [10:0] pos_max   [2];
  logic [1:0] neg_held, pos_held, neg_pend, pos_pend, neg_act, pos_act, do_move;

  logic [2:0] color_reg;
  logic [7:0] rgb_reg;
  logic       in_x, in_y;

  assign btn_raw  = {B_C, B_R, B_L, B_D, B_U};
  assign btn_rise = btn_sync_reg & ~btn_prev_reg;

  // Falling edge of the synchronized vsync marks the start of a new frame.
  assign frame_tick = vs_prev_reg & ~vs_sync_reg;

  assign neg_held = {btn_sync_reg[0], btn_sync_reg[2]};
  assign pos_held = {btn_sync_reg[1], btn_sync_reg[3]};
  assign neg_pend = {pend_reg[0], pend_reg[2]};
  assign pos_pend = {pend_reg[1], pend_reg[3]};
  assign neg_act  = neg_held | neg_pend;
  assign pos_act  = pos_held | pos_pend;

  assign pos_max[0] = $signed(11'(H_RES - BOX));
  assign pos_max[1] = $signed(11'(V_RES - BOX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_meta_reg <= '0;
      btn_sync_reg <= '0;
      btn_prev_reg <= '0;
      vs_meta_reg  <= 1'b0;
      vs_sync_reg  <= 1'b0;
      vs_prev_reg  <= 1'b0;
      pend_reg     <= '0;
    end else begin
      btn_meta_reg <= btn_raw;
      btn_sync_reg <= btn_meta_reg;
      btn_prev_reg <= btn_sync_reg;
      vs_meta_reg  <= vsync;
      vs_sync_reg  <= vs_meta_reg;
      vs_prev_reg  <= vs_sync_reg;
      // Pending flags are consumed at every frame boundary; an edge that
      // coincides with the tick is covered by the held level at that tick.
      pend_reg     <= frame_tick ? '0 : (pend_reg | btn_rise);
    end
  end

  // Per-axis next-state logic; both axes evaluated identically.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      state_next[a] = state_reg[a];
      cnt_next[a]   = cnt_reg[a];
      do_move[a]    = 1'b0;
      if (frame_tick) begin
        if (neg_act[a] && pos_act[a]) begin
          state_next[a] = IDLE;
        end else begin
          case (state_reg[a])
            IDLE: begin
              if (neg_act[a] || pos_act[a]) begin
                do_move[a]    = 1'b1;
                state_next[a] = FIRST;
                cnt_next[a]   = CNT_LOAD;
              end
            end
            FIRST: begin
              if (neg_held[a] || pos_held[a]) begin
                if (cnt_reg[a] == '0) begin
                  state_next[a] = REPEAT;
                  do_move[a]    = 1'b1;
                end else begin
                  cnt_next[a] = cnt_reg[a] - 1'b1;
                end
              end else if (neg_pend[a] || pos_pend[a]) begin
                // released but re-tapped within the frame: treat as a fresh press
                do_move[a]    = 1'b1;
                cnt_next[a]   = CNT_LOAD;
              end else begin
                state_next[a] = IDLE;
              end
            end
            REPEAT: begin
              if (neg_held[a] || pos_held[a]) begin
                do_move[a] = 1'b1;
              end else if (neg_pend[a] || pos_pend[a]) begin
                do_move[a]    = 1'b1;
                state_next[a] = FIRST;
                cnt_next[a]   = CNT_LOAD;
              end else begin
                state_next[a] = IDLE;
              end
            end
            default: state_next[a] = IDLE;
          endcase
        end
      end
    end
  end

  // Saturating position update in 11-bit signed arithmetic.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      sum_dn[a]   = $signed({1'b0, pos_reg[a]}) - $signed(11'(STEP));
      sum_up[a]   = $signed({1'b0, pos_reg[a]}) + $signed(11'(STEP));
      pos_next[a] = pos_reg[a];
      if (do_move[a] && neg_act[a]) begin
        pos_next[a] = sum_dn[a][10] ? 10'd0 : sum_dn[a][9:0];
      end else if (do_move[a] && pos_act[a]) begin
        pos_next[a] = (sum_up[a] > pos_max[a]) ? pos_max[a][9:0] : sum_up[a][9:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int a = 0; a < 2; a++) begin
        state_reg[a] <= IDLE;
        cnt_reg[a]   <= '0;
      end
      pos_reg[0] <= 10'((H_RES - BOX) / 2);
      pos_reg[1] <= 10'((V_RES - BOX) / 2);
      color_reg  <= '0;
    end else begin
      for (int a = 0; a < 2; a++) begin
        state_reg[a] <= state_next[a];
        cnt_reg[a]   <= cnt_next[a];
        pos_reg[a]   <= pos_next[a];
      end
      if (frame_tick && (pend_reg[4] || btn_rise[4])) begin
        color_reg <= color_reg + 3'd1;
      end
    end
  end

  function automatic logic [7:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 8'hE0;
      3'd1:    palette = 8'h1C;
      3'd2:    palette = 8'h03;
      3'd3:    palette = 8'hFC;
      3'd4:    palette = 8'hE3;
      3'd5:    palette = 8'h1F;
      3'd6:    palette = 8'hFF;
      default: palette = 8'h92;
    endcase
  endfunction

  assign in_x = ({1'b0, pixel_x} >= {1'b0, pos_reg[0]}) &&
                ({1'b0, pixel_x} <  ({1'b0, pos_reg[0]} + 11'(BOX)));
  assign in_y = ({1'b0, pixel_y} >= {1'b0, pos_reg[1]}) &&
                ({1'b0, pixel_y} <  ({1'b0, pos_reg[1]} + 11'(BOX)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_reg <= 8'h00;
    end else begin
      rgb_reg <= (video_on && in_x && in_y) ? palette(color_reg) : 8'h00;
    end
  end

  assign rgb       = rgb_reg;
  assign box_x     = pos_reg[0];
  assign box_y     = pos_reg[1];
  assign color_idx = color_reg;

endmodule

// File: tb/tb_cursor_controller.sv
module tb_cursor_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       video_on = 1'b0;
  logic       vsync = 1'b1;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       B_U = 1'b0, B_D = 1'b0, B_L = 1'b0, B_R = 1'b0, B_C = 1'b0;
  logic [7:0] rgb;
  logic [9:0] box_x, box_y;
  logic [2:0] color_idx;

  int vectors = 0;
  int errors  = 0;

  cursor_controller dut (
    .clk(clk), .reset(reset), .video_on(video_on), .vsync(vsync),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .B_U(B_U), .B_D(B_D), .B_L(B_L), .B_R(B_R), .B_C(B_C),
    .rgb(rgb), .box_x(box_x), .box_y(box_y), .color_idx(color_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(2);
  endtask

  // One vsync low pulse; returns after the frame-tick update has settled.
  task automatic frame();
    @(negedge clk);
    vsync = 1'b0;
    cycles(3);
    vsync = 1'b1;
    cycles(4);
  endtask

  task automatic press_c();
    @(negedge clk);
    B_C = 1'b1;
    cycles(3);
    B_C = 1'b0;
    cycles(3);
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic von,
                     input logic [7:0] prev_exp, input logic [7:0] exp, input string tag);
    @(negedge clk);
    pixel_x = x; pixel_y = y; video_on = von;
    #1;
    chk({tag, "_hold"}, 10'(rgb), 10'(prev_exp));
    @(negedge clk);
    chk(tag, 10'(rgb), 10'(exp));
  endtask

  initial begin
    int m, e;

    // Reset state
    do_reset();
    chk("rst_box_x", box_x, 10'd304);
    chk("rst_box_y", box_y, 10'd224);
    chk("rst_color", 10'(color_idx), 10'd0);
    chk("rst_rgb", 10'(rgb), 10'd0);

    // Short B_R tap mid-frame -> single move right
    @(negedge clk); B_R = 1'b1; cycles(3); B_R = 1'b0; cycles(5);
    chk("tap_r_before_tick", box_x, 10'd304);
    frame();
    chk("tap_r_box_x", box_x, 10'd312);
    chk("tap_r_box_y", box_y, 10'd224);
    pix(10'd312, 10'd224, 1'b1, 8'h00, 8'hE0, "tap_r_rgb_in");
    pix(10'd311, 10'd224, 1'b1, 8'hE0, 8'h00, "tap_r_rgb_left");
    video_on = 1'b0;
    frame();
    chk("tap_r_no_repeat", box_x, 10'd312);

    // Hold B_U for 20 frames: move, 7 idle frames, then one move per frame
    do_reset();
    @(negedge clk); B_U = 1'b1; cycles(4);
    for (int f = 1; f <= 20; f++) begin
      frame();
      m = (f < 9) ? 1 : f - 7;
      chk($sformatf("hold_u_f%0d", f), box_y, 10'(224 - 8 * m));
    end
    B_U = 1'b0; cycles(3);
    frame();
    chk("hold_u_released", box_y, 10'd120);
    chk("hold_u_x_still", box_x, 10'd304);

    // Reset while held discards motion; held button counts as a new press
    do_reset();
    @(negedge clk); B_U = 1'b1; cycles(4);
    frame();
    chk("rmid_first", box_y, 10'd216);
    frame();
    chk("rmid_wait", box_y, 10'd216);
    do_reset();
    chk("rmid_after_rst", box_y, 10'd224);
    frame();
    chk("rmid_new_press", box_y, 10'd216);
    B_U = 1'b0;

    // Left saturation at 0
    do_reset();
    @(negedge clk); B_L = 1'b1; cycles(4);
    for (int f = 1; f <= 50; f++) begin
      frame();
      m = (f < 9) ? 1 : f - 7;
      e = 304 - 8 * m;
      if (e < 0) e = 0;
      chk($sformatf("sat_l_f%0d", f), box_x, 10'(e));
    end
    B_L = 1'b0;

    // Right saturation at 608
    do_reset();
    @(negedge clk); B_R = 1'b1; cycles(4);
    for (int f = 1; f <= 50; f++) begin
      frame();
      m = (f < 9) ? 1 : f - 7;
      e = 304 + 8 * m;
      if (e > 608) e = 608;
      chk($sformatf("sat_r_f%0d", f), box_x, 10'(e));
    end
    B_R = 1'b0;

    // Opposite directions cancel; vertical axis still moves
    do_reset();
    @(negedge clk); B_L = 1'b1; B_R = 1'b1; B_D = 1'b1; cycles(4);
    frame();
    chk("opp_box_x", box_x, 10'd304);
    chk("opp_box_y", box_y, 10'd232);
    B_L = 1'b0; B_R = 1'b0; B_D = 1'b0; cycles(4);
    frame();
    chk("opp_release_x", box_x, 10'd304);
    chk("opp_release_y", box_y, 10'd232);
    @(negedge clk); B_R = 1'b1; cycles(4);
    frame();
    chk("opp_x_was_idle", box_x, 10'd312);
    B_R = 1'b0; cycles(4);

    // Colour cycling
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      press_c();
      frame();
      chk($sformatf("color_%0d", i), 10'(color_idx), 10'(i % 8));
    end
    press_c();
    press_c();
    chk("color_before_tick", 10'(color_idx), 10'd0);
    frame();
    chk("color_double_press", 10'(color_idx), 10'd1);
    pix(10'd304, 10'd224, 1'b1, 8'h00, 8'h1C, "color1_rgb");
    pix(10'd304, 10'd224, 1'b0, 8'h1C, 8'h00, "color1_blank");

    // Pixel scan around the box at (304,224), colour 0
    do_reset();
    pix(10'd304, 10'd224, 1'b1, 8'h00, 8'hE0, "scan_tl");
    pix(10'd336, 10'd224, 1'b1, 8'hE0, 8'h00, "scan_right_out");
    pix(10'd335, 10'd255, 1'b1, 8'h00, 8'hE0, "scan_br");
    pix(10'd303, 10'd224, 1'b1, 8'hE0, 8'h00, "scan_left_out");
    pix(10'd320, 10'd240, 1'b1, 8'h00, 8'hE0, "scan_mid");
    pix(10'd320, 10'd240, 1'b0, 8'hE0, 8'h00, "scan_blank");
    pix(10'd320, 10'd256, 1'b1, 8'h00, 8'h00, "scan_below_out");
    pix(10'd320, 10'd223, 1'b1, 8'h00, 8'h00, "scan_above_out");
    pix(10'd335, 10'd224, 1'b1, 8'h00, 8'hE0, "scan_tr");
    video_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cursor_controller.md
CURSOR_CONTROLLER -- requirements
Module: cursor_controller

Interface
REQ-001 Parameter H_RES, default 640, visible pixels per line.
REQ-002 Parameter V_RES, default 480, visible lines per frame.
REQ-003 Parameter BOX, default 32, cursor square side in pixels.
REQ-004 Parameter STEP, default 8, pixels moved per move event.
REQ-005 Parameter REPEAT_FRAMES, default 8, frames a direction is held before auto-repeat.
REQ-006 clk  in  1  pixel-domain clock; one clock, all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 video_on  in  1  high while pixel_x/pixel_y are inside the visible area.
REQ-009 vsync  in  1  vertical sync from the sync generator, active-low pulse.
REQ-010 pixel_x  in  10  current pixel column.
REQ-011 pixel_y  in  10  current pixel row.
REQ-012 B_U, B_D, B_L, B_R, B_C  in  1 each  debounced buttons (up, down, left, right, center), active-high, asynchronous to clk.
REQ-013 rgb  out  8  RGB332 pixel colour, registered.
REQ-014 box_x  out  10  cursor left edge.
REQ-015 box_y  out  10  cursor top edge.
REQ-016 color_idx  out  3  current palette index.

Function
REQ-017 Each button SHALL pass a 2-flop synchronizer before any use.
REQ-018 frame_tick SHALL be a 1-cycle pulse on the clock after the synchronized vsync goes 1->0.
REQ-019 box_x, box_y and color_idx SHALL change only in the cycle following frame_tick, so the cursor never tears mid-frame.
REQ-020 A rising edge on a direction button SHALL set a sticky pending flag for that direction, cleared at the next frame_tick.
REQ-021 Per-axis FSM states SHALL be IDLE, FIRST and REPEAT.
REQ-022 IDLE to FIRST: at frame_tick with a pending flag or a held button; one STEP move applied; repeat counter loaded with REPEAT_FRAMES-1.
REQ-023 FIRST: counter decrements at each frame_tick while the button is held; at 0 it SHALL go to REPEAT.
REQ-024 REPEAT: one STEP move SHALL be applied at every frame_tick while the button is held.
REQ-025 FIRST or REPEAT to IDLE: at any frame_tick where the axis button is released and no flag is pending; no move is applied at that tick.
REQ-026 A press and release within one frame SHALL still yield exactly one move via the pending flag.
REQ-027 Opposite directions (U with D, or L with R) both active at a frame_tick SHALL apply no move on that axis and return that axis FSM to IDLE.
REQ-028 The two axes SHALL be independent; diagonal moves are allowed in the same frame.
REQ-029 Positions SHALL saturate: box_x in [0, H_RES-BOX], box_y in [0, V_RES-BOX].
REQ-030 Arithmetic SHALL be 11-bit signed, so a move that would leave the range clamps to the bound instead of wrapping.
REQ-031 A B_C rising edge SHALL set a pending color flag.
REQ-032 At frame_tick, a pending color flag SHALL advance color_idx by 1 modulo 8 (7->0); multiple presses within one frame count once.
REQ-033 Palette: 0:E0, 1:1C, 2:03, 3:FC, 4:E3, 5:1F, 6:FF, 7:92.
REQ-034 rgb SHALL be registered with 1-cycle latency from pixel_x/pixel_y/video_on.
REQ-035 rgb SHALL be palette[color_idx] when video_on and box_x<=pixel_x<box_x+BOX and box_y<=pixel_y<box_y+BOX.
REQ-036 rgb SHALL be 8'h00 when video_on and the pixel is outside the box.
REQ-037 rgb SHALL be 8'h00 when video_on=0.

Reset
REQ-038 reset=0 sampled at a clock edge SHALL set: box_x=(H_RES-BOX)/2 (304), box_y=(V_RES-BOX)/2 (224), color_idx=0, rgb=8'h00.
REQ-039 reset=0 SHALL also set both axis FSMs to IDLE, clear all pending flags, clear the edge detectors and set the synchronizer flops to 0.
REQ-040 Reset asserted mid-move or mid-repeat SHALL discard pending motion; after release, a held button counts as a new rising edge.

Verification
REQ-041 Reset, then one B_R press of 3 cycles mid-frame -> next frame_tick: box_x 304->312, box_y stays 224, rgb inside box = E0.
REQ-042 Hold B_U continuously for 20 frames -> box_y drops 8 at frame 1, then no further moves until REPEAT is reached (frame 9), then 8 per frame; final box_y = 224-8*13 = 120.
REQ-043 Hold B_L from box_x=8 -> box_x=0 next tick and stays 0 on all later ticks; with box_x=600, B_R -> 608, then held -> stays 608.
REQ-044 B_L and B_R both held across a frame_tick -> box_x unchanged, horizontal FSM IDLE; B_D in the same frame still moves box_y by +8.
REQ-045 Eight B_C presses in separate frames -> color_idx 1,2,...,7,0; two B_C presses in one frame -> single increment.
REQ-046 Pixel scan with box at (304,224) -> rgb equals palette at pixels (304,224) and (335,255); rgb=00 at (336,224) and (303,224); rgb=00 whenever video_on=0; every case observed 1 cycle after its input.
